// File: rtl/pc_unit_if.sv
// pc_unit_if: fetch-control bundle between decode/compare logic and the PC unit.
// master drives control and operands, slave (the PC unit) returns PC state.
interface pc_unit_if #(
  parameter int XLEN = 64
);
  logic            LOAD;
  logic [6:0]      opcode;
  logic [2:0]      func;
  logic [XLEN-1:0] immediate;
  logic [XLEN-1:0] rs1_val;
  logic            EQ;
  logic            LT_SN;
  logic            LT_UN;
  logic [1:0]      instr_lo;
  logic            trap_req;
  logic            mret;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] pc_link;
  logic [XLEN-1:0] epc;
  logic            in_trap;
  logic            trap_taken;

  modport master (
    output LOAD, opcode, func, immediate, rs1_val,
    output EQ, LT_SN, LT_UN, instr_lo, trap_req, mret,
    input  addr, pc_link, epc, in_trap, trap_taken
  );

  modport slave (
    input  LOAD, opcode, func, immediate, rs1_val,
    input  EQ, LT_SN, LT_UN, instr_lo, trap_req, mret,
    output addr, pc_link, epc, in_trap, trap_taken
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: program counter with branch/JAL/JALR, stall, misaligned trap, mret.
// Optional macro PC_COMPRESSED_EN: 2-byte steps for 16-bit instructions.
module pc_unit #(
  parameter int              XLEN       = 64,
  parameter logic [XLEN-1:0] RESET_ADDR = '0,
  parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'('h100)
) (
  input  logic     CLK,
  input  logic     RST,
  pc_unit_if.slave bus
);

  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef enum logic {S_RUN, S_TRAP} state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_epc;
  logic            r_trap_taken;
  logic            r_in_trap;

  logic [XLEN-1:0] w_step;
  logic [XLEN-1:0] w_seq;
  logic [XLEN-1:0] w_jalr_sum;
  logic [XLEN-1:0] w_target;
  logic            w_is_br;
  logic            w_is_jal;
  logic            w_is_jalr;
  logic            w_br_cond;
  logic            w_taken;
  logic            w_misal;
  logic            w_trap;

`ifdef PC_COMPRESSED_EN
  assign w_step  = (bus.instr_lo != 2'b11) ? XLEN'(2) : XLEN'(4);
  // 2-byte aligned targets are guaranteed, so no fault check here
  assign w_misal = 1'b0;
`else
  logic w_unused_lo;
  assign w_unused_lo = ^bus.instr_lo;
  assign w_step  = XLEN'(4);
  assign w_misal = w_taken & w_target[1];
`endif

  assign w_seq      = r_addr + w_step;
  assign w_is_br    = (bus.opcode == OP_BR);
  assign w_is_jal   = (bus.opcode == OP_JAL);
  assign w_is_jalr  = (bus.opcode == OP_JALR);
  assign w_jalr_sum = bus.rs1_val + bus.immediate;

  // branch condition from funct3 and comparator flags
  always_comb begin
    w_br_cond = 1'b0;
    case (bus.func)
      3'b000:  w_br_cond = bus.EQ;
      3'b001:  w_br_cond = ~bus.EQ;
      3'b100:  w_br_cond = bus.LT_SN;
      3'b101:  w_br_cond = ~bus.LT_SN;
      3'b110:  w_br_cond = bus.LT_UN;
      3'b111:  w_br_cond = ~bus.LT_UN;
      default: w_br_cond = 1'b0;
    endcase
  end

  assign w_taken  = (w_is_br & w_br_cond) | w_is_jal | w_is_jalr;
  assign w_target = w_is_jalr
                  ? (w_jalr_sum & ~XLEN'(1))
                  : (r_addr + bus.immediate);
  assign w_trap   = bus.trap_req | w_misal;

  // PC / trap FSM, advancing on the falling edge when LOAD is high
  always_ff @(negedge CLK) begin
    if (RST) begin
      r_state      <= S_RUN;
      r_addr       <= RESET_ADDR;
      r_epc        <= '0;
      r_trap_taken <= 1'b0;
      r_in_trap    <= 1'b0;
    end else if (!bus.LOAD) begin
      r_trap_taken <= 1'b0;
    end else begin
      r_trap_taken <= 1'b0;
      if (w_trap) begin
        r_addr       <= TRAP_VEC;
        r_trap_taken <= 1'b1;
        if (r_state == S_RUN) begin
          r_epc     <= r_addr;
          r_state   <= S_TRAP;
          r_in_trap <= 1'b1;
        end
      end else if (bus.mret) begin
        if (r_state == S_TRAP) begin
          r_addr    <= r_epc;
          r_state   <= S_RUN;
          r_in_trap <= 1'b0;
        end else begin
          r_addr <= w_seq;
        end
      end else if (w_taken) begin
        r_addr <= w_target;
      end else begin
        r_addr <= w_seq;
      end
    end
  end

  assign bus.addr       = r_addr;
  assign bus.pc_link    = w_seq;
  assign bus.epc        = r_epc;
  assign bus.in_trap    = r_in_trap;
  assign bus.trap_taken = r_trap_taken;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed scenarios plus randomized traffic against a
// behavioural PC model; honours PC_COMPRESSED_EN like the design.
module tb_pc_unit;

  typedef logic [63:0] w_t;

  localparam w_t TV = 64'h100;
`ifdef PC_COMPRESSED_EN
  localparam w_t EPC0 = 64'h1002;
`else
  localparam w_t EPC0 = 64'h80;
`endif

  logic CLK = 1'b0;
  logic RST;

  pc_unit_if #(.XLEN(64)) bus ();

  pc_unit #(
    .XLEN(64),
    .RESET_ADDR(64'h0),
    .TRAP_VEC(64'h100)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  w_t m_addr;
  w_t m_epc;
  bit m_it;
  bit m_tt;
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(string tag, w_t got, w_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic w_t isz(logic [1:0] lo);
`ifdef PC_COMPRESSED_EN
    return (lo == 2'b11) ? 64'd4 : 64'd2;
`else
    return (lo == 2'b11) ? 64'd4 : 64'd4;
`endif
  endfunction

  function automatic bit br_ok(logic [2:0] f, bit eq, bit lts, bit ltu);
    case (f)
      3'd0: return eq;
      3'd1: return !eq;
      3'd4: return lts;
      3'd5: return !lts;
      3'd6: return ltu;
      3'd7: return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  // Reference: apply one update using the architectural rules
  task automatic model();
    bit jump, bad;
    w_t tgt;
    if (RST) begin
      m_addr = 64'h0; m_epc = 64'h0; m_it = 0; m_tt = 0;
      return;
    end
    if (!bus.LOAD) begin
      m_tt = 0;
      return;
    end
    m_tt = 0;
    jump = 0;
    tgt = m_addr + bus.immediate;
    if (bus.opcode == 7'b1100011)
      jump = br_ok(bus.func, bus.EQ, bus.LT_SN, bus.LT_UN);
    if (bus.opcode == 7'b1101111) jump = 1;
    if (bus.opcode == 7'b1100111) begin
      jump = 1;
      tgt = (bus.rs1_val + bus.immediate) & ~64'd1;
    end
`ifdef PC_COMPRESSED_EN
    bad = 0;
`else
    bad = jump && tgt[1];
`endif
    if (bus.trap_req || bad) begin
      if (!m_it) begin m_epc = m_addr; m_it = 1; end
      m_addr = TV;
      m_tt = 1;
    end else if (bus.mret && m_it) begin
      m_addr = m_epc;
      m_it = 0;
    end else if (jump && !bus.mret) begin
      m_addr = tgt;
    end else begin
      m_addr = m_addr + isz(bus.instr_lo);
    end
  endtask

  task automatic tick();
    model();
    @(negedge CLK);
    #1;
    chk("addr", bus.addr, m_addr);
    chk("epc", bus.epc, m_epc);
    chk("in_trap", 64'(bus.in_trap), 64'(m_it));
    chk("trap_taken", 64'(bus.trap_taken), 64'(m_tt));
    chk("pc_link", bus.pc_link, m_addr + isz(bus.instr_lo));
  endtask

  task automatic idle();
    bus.LOAD = 1; bus.opcode = 7'b0010011; bus.func = 3'd0;
    bus.immediate = '0; bus.rs1_val = '0;
    bus.EQ = 0; bus.LT_SN = 0; bus.LT_UN = 0;
    bus.instr_lo = 2'b11; bus.trap_req = 0; bus.mret = 0;
  endtask

  task automatic jal(w_t imm);
    idle(); bus.opcode = 7'b1101111; bus.immediate = imm; tick();
  endtask

  task automatic seq();
    idle(); tick();
  endtask

  initial begin
    idle();
    RST = 1;
    tick();
    chk("rst_addr", bus.addr, 64'h0);
    chk("rst_tt", 64'(bus.trap_taken), 64'h0);
    RST = 0;

    seq(); seq(); seq();
    chk("seq3_addr", bus.addr, 64'hc);
    chk("seq3_link", bus.pc_link, 64'h10);

    jal(64'h14);
    chk("jal_20", bus.addr, 64'h20);
    idle(); bus.opcode = 7'b1100011; bus.func = 3'd1;
    bus.immediate = 64'h40; bus.EQ = 0; tick();
    chk("bne_taken", bus.addr, 64'h60);
    jal(-64'h40);
    idle(); bus.opcode = 7'b1100011; bus.func = 3'd1;
    bus.immediate = 64'h40; bus.EQ = 1; tick();
    chk("bne_not", bus.addr, 64'h24);
    idle(); bus.opcode = 7'b1100011; bus.func = 3'd5;
    bus.immediate = 64'h10; bus.LT_SN = 0; tick();
    chk("bge_taken", bus.addr, 64'h34);

    jal(64'h4c);
    chk("jal_80", bus.addr, 64'h80);
    idle(); bus.opcode = 7'b1100111;
    bus.rs1_val = 64'h1001; bus.immediate = 64'h2; tick();
`ifdef PC_COMPRESSED_EN
    chk("jalr_c", bus.addr, 64'h1002);
    chk("jalr_c_it", 64'(bus.in_trap), 64'h0);
    idle(); bus.trap_req = 1; tick();
`endif
    chk("trap_addr", bus.addr, TV);
    chk("trap_epc", bus.epc, EPC0);
    chk("trap_it", 64'(bus.in_trap), 64'h1);
    chk("trap_tt", 64'(bus.trap_taken), 64'h1);

    for (int i = 0; i < 3; i++) begin
      idle(); bus.LOAD = 0; bus.opcode = 7'b1101111;
      bus.immediate = 64'h40; bus.trap_req = 1; tick();
    end
    chk("stall_addr", bus.addr, TV);
    chk("stall_epc", bus.epc, EPC0);
    chk("stall_it", 64'(bus.in_trap), 64'h1);
    chk("stall_tt", 64'(bus.trap_taken), 64'h0);

    seq(); seq(); seq(); seq();
    chk("at_110", bus.addr, 64'h110);
    idle(); bus.trap_req = 1; tick();
    chk("nest_addr", bus.addr, TV);
    chk("nest_epc", bus.epc, EPC0);
    idle(); bus.opcode = 7'b1110011; bus.mret = 1; tick();
    chk("mret_addr", bus.addr, EPC0);
    chk("mret_it", 64'(bus.in_trap), 64'h0);

    jal(-64'd4 - EPC0);
    chk("top_addr", bus.addr, 64'hffff_ffff_ffff_fffc);
    seq();
    chk("wrap_addr", bus.addr, 64'h0);
    idle(); bus.trap_req = 1; tick();
    idle(); RST = 1; tick();
    RST = 0;
    chk("rst2_addr", bus.addr, 64'h0);
    chk("rst2_epc", bus.epc, 64'h0);
    chk("rst2_it", 64'(bus.in_trap), 64'h0);

    for (int i = 0; i < 600; i++) begin
      int k;
      longint simm;
      idle();
      k = int'($urandom_range(0, 5));
      case (k)
        0: bus.opcode = 7'b1100011;
        1: bus.opcode = 7'b1101111;
        2: bus.opcode = 7'b1100111;
        3: bus.opcode = 7'b0010011;
        4: bus.opcode = 7'b1110011;
        default: bus.opcode = 7'b0000011;
      endcase
      simm = longint'(int'($urandom_range(0, 1023)) - 512);
      bus.immediate = w_t'(simm) & ~64'd1;
      bus.rs1_val = {$urandom, $urandom};
      bus.func = 3'($urandom_range(0, 7));
      bus.EQ = 1'($urandom_range(0, 1));
      bus.LT_SN = 1'($urandom_range(0, 1));
      bus.LT_UN = 1'($urandom_range(0, 1));
      bus.instr_lo = 2'($urandom_range(0, 3));
      bus.mret = (k == 4) && ($urandom_range(0, 1) == 0);
      bus.trap_req = ($urandom_range(0, 19) == 0);
      bus.LOAD = ($urandom_range(0, 4) != 0);
      RST = ($urandom_range(0, 59) == 0);
      tick();
    end
    RST = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
